// File: rtl/bus_arbiter2_pkg.sv
// Shared definitions for the two-master system bus front end:
// default geometry, slave windows and arbiter state encoding.
package bus_arbiter2_pkg;

    localparam int BUS_AW = 16;
    localparam int BUS_DW = 64;

    localparam logic [15:0] BUS_S0_BASE = 16'h0000;
    localparam logic [15:0] BUS_S1_BASE = 16'h0020;
    localparam logic [15:0] BUS_S_MASK  = 16'hFFE0;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ST_IDLE = 2'd0;
    localparam arb_state_t ST_GNT0 = 2'd1;
    localparam arb_state_t ST_GNT1 = 2'd2;

endpackage

// File: rtl/bus_addr_decode.sv
// Slave window decode: compares a bus address against the two slave windows.
// Shared with the single-master bus front end.
module bus_addr_decode
    import bus_arbiter2_pkg::*;
#(
    parameter int            AW      = BUS_AW,
    parameter logic [AW-1:0] S0_BASE = BUS_S0_BASE,
    parameter logic [AW-1:0] S1_BASE = BUS_S1_BASE,
    parameter logic [AW-1:0] S_MASK  = BUS_S_MASK
) (
    input  logic          en,
    input  logic [AW-1:0] addr,
    output logic          s0_sel,
    output logic          s1_sel
);

    localparam logic [AW-1:0] WIN_BASE [2] = '{S0_BASE, S1_BASE};

    logic [1:0] hit;

    for (genvar gi = 0; gi < 2; gi++) begin : g_win
        assign hit[gi] = en & ((addr & S_MASK) == WIN_BASE[gi]);
    end

    assign s0_sel = hit[0];
    assign s1_sel = hit[1];

endmodule

// File: rtl/bus_arbiter2.sv
// Two-master bus front end: hold-until-release arbitration with bounded
// tenure, slave-side mux, window decode and one-cycle read return.
module bus_arbiter2
    import bus_arbiter2_pkg::*;
#(
    parameter int            AW       = BUS_AW,
    parameter int            DW       = BUS_DW,
    parameter logic [AW-1:0] S0_BASE  = BUS_S0_BASE,
    parameter logic [AW-1:0] S1_BASE  = BUS_S1_BASE,
    parameter logic [AW-1:0] S_MASK   = BUS_S_MASK,
    parameter int            HOLD_MAX = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          m0_req,
    input  logic          m1_req,
    input  logic          m0_wr,
    input  logic          m1_wr,
    input  logic [AW-1:0] m0_addr,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m0_dout,
    input  logic [DW-1:0] m1_dout,
    input  logic [DW-1:0] s0_dout,
    input  logic [DW-1:0] s1_dout,
    output logic          m0_grant,
    output logic          m1_grant,
    output logic [DW-1:0] m_din,
    output logic          s0_sel,
    output logic          s1_sel,
    output logic [AW-1:0] s_addr,
    output logic          s_wr,
    output logic [DW-1:0] s_din
);

    localparam int            HW         = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam logic [HW-1:0] HOLD_LAST  = (HOLD_MAX > 0) ? HW'(HOLD_MAX - 1) : '0;
    localparam logic          PREEMPT_EN = (HOLD_MAX != 0);

    arb_state_t    state_reg, state_next;
    logic [HW-1:0] hold_cnt_reg, hold_cnt_next;
    logic [1:0]    rd_sel_reg, rd_sel_next;
    logic          tenure_up;

    assign tenure_up = PREEMPT_EN && (hold_cnt_reg == HOLD_LAST);

    // Holder keeps the bus while requesting unless its tenure has expired
    // and the other master is waiting; switches go master-to-master directly.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (m0_req)      state_next = ST_GNT0;
                else if (m1_req) state_next = ST_GNT1;
            end
            ST_GNT0: begin
                if (tenure_up && m1_req) state_next = ST_GNT1;
                else if (m0_req)         state_next = ST_GNT0;
                else if (m1_req)         state_next = ST_GNT1;
                else                     state_next = ST_IDLE;
            end
            ST_GNT1: begin
                if (tenure_up && m0_req) state_next = ST_GNT0;
                else if (m1_req)         state_next = ST_GNT1;
                else if (m0_req)         state_next = ST_GNT0;
                else                     state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        hold_cnt_next = hold_cnt_reg;
        if (state_next != state_reg || state_next == ST_IDLE) begin
            hold_cnt_next = '0;
        end else if (hold_cnt_reg != HOLD_LAST) begin
            hold_cnt_next = hold_cnt_reg + HW'(1);
        end
    end

    assign m0_grant = (state_reg == ST_GNT0);
    assign m1_grant = (state_reg == ST_GNT1);

    always_comb begin
        s_addr = '0;
        s_wr   = 1'b0;
        s_din  = '0;
        case (state_reg)
            ST_GNT0: begin
                s_addr = m0_addr;
                s_wr   = m0_wr;
                s_din  = m0_dout;
            end
            ST_GNT1: begin
                s_addr = m1_addr;
                s_wr   = m1_wr;
                s_din  = m1_dout;
            end
            default: ;
        endcase
    end

    bus_addr_decode #(
        .AW      (AW),
        .S0_BASE (S0_BASE),
        .S1_BASE (S1_BASE),
        .S_MASK  (S_MASK)
    ) u_decode (
        .en     (m0_grant | m1_grant),
        .addr   (s_addr),
        .s0_sel (s0_sel),
        .s1_sel (s1_sel)
    );

    // Remembers which slave a read went to, so data is steered correctly
    // even after the grant has moved to the other master.
    assign rd_sel_next = {s1_sel & ~s_wr, s0_sel & ~s_wr};

    always_comb begin
        m_din = '0;
        if (rd_sel_reg[0])      m_din = s0_dout;
        else if (rd_sel_reg[1]) m_din = s1_dout;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg    <= ST_IDLE;
            hold_cnt_reg <= '0;
            rd_sel_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            hold_cnt_reg <= hold_cnt_next;
            rd_sel_reg   <= rd_sel_next;
        end
    end

endmodule

// File: tb/tb_bus_arbiter2.sv
// Self-checking bench for bus_arbiter2: behavioural slaves plus a read-data
// scoreboard; a second instance with tenure limiting disabled.
module tb_bus_arbiter2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        m0_req, m1_req, m0_wr, m1_wr;
    logic [15:0] m0_addr, m1_addr;
    logic [63:0] m0_dout, m1_dout;
    logic [63:0] s0_dout, s1_dout;
    logic        m0_grant, m1_grant, s0_sel, s1_sel, s_wr;
    logic [63:0] m_din, s_din;
    logic [15:0] s_addr;
    logic        nh_m0_grant, nh_m1_grant, nh_s0_sel, nh_s1_sel, nh_s_wr;
    logic [63:0] nh_m_din, nh_s_din;
    logic [15:0] nh_s_addr;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];
    logic [63:0] exp_v;
    logic [63:0] mem0 [32];
    logic [63:0] mem1 [32];

    always #5 clk = ~clk;

    bus_arbiter2 #(.HOLD_MAX(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_req(m0_req), .m1_req(m1_req), .m0_wr(m0_wr), .m1_wr(m1_wr),
        .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_dout(m0_dout), .m1_dout(m1_dout),
        .s0_dout(s0_dout), .s1_dout(s1_dout),
        .m0_grant(m0_grant), .m1_grant(m1_grant), .m_din(m_din),
        .s0_sel(s0_sel), .s1_sel(s1_sel), .s_addr(s_addr), .s_wr(s_wr), .s_din(s_din)
    );

    bus_arbiter2 #(.HOLD_MAX(0)) dut_nh (
        .clk(clk), .reset_n(reset_n),
        .m0_req(m0_req), .m1_req(m1_req), .m0_wr(m0_wr), .m1_wr(m1_wr),
        .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_dout(m0_dout), .m1_dout(m1_dout),
        .s0_dout(64'd0), .s1_dout(64'd0),
        .m0_grant(nh_m0_grant), .m1_grant(nh_m1_grant), .m_din(nh_m_din),
        .s0_sel(nh_s0_sel), .s1_sel(nh_s1_sel), .s_addr(nh_s_addr), .s_wr(nh_s_wr), .s_din(nh_s_din)
    );

    // Slaves: write on select, read data one cycle later, junk when not read.
    always @(posedge clk) begin
        if (s0_sel === 1'b1 && s_wr === 1'b1) mem0[s_addr[4:0]] <= s_din;
        if (s1_sel === 1'b1 && s_wr === 1'b1) mem1[s_addr[4:0]] <= s_din;
        s0_dout <= (s0_sel === 1'b1 && s_wr === 1'b0) ? mem0[s_addr[4:0]] : 64'hBAD0_BAD0_BAD0_BAD0;
        s1_dout <= (s1_sel === 1'b1 && s_wr === 1'b0) ? mem1[s_addr[4:0]] : 64'hBAD1_BAD1_BAD1_BAD1;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        m0_req = 1'b1; m0_wr = 1'b1; m0_addr = 16'h0010; m0_dout = 64'h1111;
        m1_req = 1'b1; m1_wr = 1'b1; m1_addr = 16'h0021; m1_dout = 64'h2121;
        cyc();
        cyc();
        @(negedge clk);
        checks++;
        if ({m0_grant, m1_grant, s0_sel, s1_sel, s_wr} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 00000", {m0_grant, m1_grant, s0_sel, s1_sel, s_wr});
        end
        checks++;
        if (s_addr !== 16'h0 || s_din !== 64'h0) begin
            errors++; $display("FAIL reset_bus: s_addr=%h s_din=%h expected 0", s_addr, s_din);
        end
        checks++;
        if (m_din !== 64'h0) begin
            errors++; $display("FAIL reset_m_din: got %h expected 0", m_din);
        end
        cyc();
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (m0_grant !== 1'b0) begin
            errors++; $display("FAIL reset_release_latency: m0_grant=%b expected 0", m0_grant);
        end
        cyc();
        m0_req = 1'b0; m1_req = 1'b0; m0_wr = 1'b0; m1_wr = 1'b0;
        @(negedge clk);
        checks++;
        if (m0_grant !== 1'b1 || m1_grant !== 1'b0) begin
            errors++; $display("FAIL reset_first_grant: m0/m1=%b%b expected 10", m0_grant, m1_grant);
        end
        cyc();
        @(negedge clk);
        checks++;
        if (m0_grant !== 1'b0 || m1_grant !== 1'b0) begin
            errors++; $display("FAIL reset_release: m0/m1=%b%b expected 00", m0_grant, m1_grant);
        end
    endtask

    task automatic test_single_rw();
        m1_req = 1'b1; m1_wr = 1'b1; m1_addr = 16'h0010; m1_dout = 64'h2222;
        cyc();
        @(negedge clk);
        checks++;
        if ({m0_grant, m1_grant, s0_sel, s1_sel, s_wr} !== 5'b01101) begin
            errors++; $display("FAIL rw_write_ctrl: got %b expected 01101", {m0_grant, m1_grant, s0_sel, s1_sel, s_wr});
        end
        checks++;
        if (s_addr !== 16'h0010 || s_din !== 64'h2222) begin
            errors++; $display("FAIL rw_write_bus: s_addr=%h s_din=%h expected 0010/2222", s_addr, s_din);
        end
        cyc();
        m1_req = 1'b0; m1_wr = 1'b0;
        exp_q.push_back(64'h2222);
        @(negedge clk);
        checks++;
        if ({m1_grant, s0_sel, s1_sel, s_wr} !== 4'b1100) begin
            errors++; $display("FAIL rw_read_ctrl: got %b expected 1100", {m1_grant, s0_sel, s1_sel, s_wr});
        end
        cyc();
        @(negedge clk);
        exp_v = exp_q.pop_front();
        checks++;
        $display("rd rw m_din=%h", m_din);
        if (m_din !== exp_v) begin
            errors++; $display("FAIL rw_read_data: got %h expected %h", m_din, exp_v);
        end
        checks++;
        if (m1_grant !== 1'b0) begin
            errors++; $display("FAIL rw_release: m1_grant=%b expected 0", m1_grant);
        end
    endtask

    task automatic test_decode();
        m0_req = 1'b1; m0_wr = 1'b1; m0_addr = 16'h0020; m0_dout = 64'h3333;
        cyc();
        @(negedge clk);
        checks++;
        if ({s0_sel, s1_sel} !== 2'b01) begin
            errors++; $display("FAIL dec_s1_base: sel=%b expected 01", {s0_sel, s1_sel});
        end
        cyc();
        m0_addr = 16'h001F; m0_dout = 64'h1F1F;
        @(negedge clk);
        checks++;
        if ({s0_sel, s1_sel} !== 2'b10) begin
            errors++; $display("FAIL dec_s0_top: sel=%b expected 10", {s0_sel, s1_sel});
        end
        cyc();
        m0_wr = 1'b0; m0_addr = 16'h0020;
        exp_q.push_back(64'h3333);
        @(negedge clk);
        checks++;
        if ({s0_sel, s1_sel, s_wr} !== 3'b010) begin
            errors++; $display("FAIL dec_s1_read: got %b expected 010", {s0_sel, s1_sel, s_wr});
        end
        cyc();
        m0_addr = 16'hFFF0;
        exp_q.push_back(64'h0);
        @(negedge clk);
        exp_v = exp_q.pop_front();
        checks++;
        $display("rd dec_s1 m_din=%h", m_din);
        if (m_din !== exp_v) begin
            errors++; $display("FAIL dec_s1_data: got %h expected %h", m_din, exp_v);
        end
        checks++;
        if ({m0_grant, s0_sel, s1_sel} !== 3'b100) begin
            errors++; $display("FAIL dec_unmapped_rd: got %b expected 100", {m0_grant, s0_sel, s1_sel});
        end
        cyc();
        m0_req = 1'b0; m0_wr = 1'b1; m0_dout = 64'hDEAD;
        @(negedge clk);
        exp_v = exp_q.pop_front();
        checks++;
        $display("rd dec_unmapped m_din=%h", m_din);
        if (m_din !== exp_v) begin
            errors++; $display("FAIL dec_unmapped_data: got %h expected %h", m_din, exp_v);
        end
        checks++;
        if ({s0_sel, s1_sel, s_wr} !== 3'b001) begin
            errors++; $display("FAIL dec_unmapped_wr: got %b expected 001", {s0_sel, s1_sel, s_wr});
        end
        cyc();
        m0_wr = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_handover();
        m0_req = 1'b1; m0_wr = 1'b1; m0_addr = 16'h0003; m0_dout = 64'h0303;
        m1_req = 1'b1; m1_wr = 1'b1; m1_addr = 16'h0021; m1_dout = 64'h2121;
        cyc();
        @(negedge clk);
        checks++;
        if ({m0_grant, m1_grant} !== 2'b10 || s_addr !== 16'h0003) begin
            errors++; $display("FAIL ho_simul: grants=%b s_addr=%h expected 10/0003", {m0_grant, m1_grant}, s_addr);
        end
        cyc();
        m0_req = 1'b0; m0_wr = 1'b0; m0_addr = 16'h0020;
        exp_q.push_back(64'h3333);
        @(negedge clk);
        checks++;
        if ({m0_grant, m1_grant, s1_sel} !== 3'b101) begin
            errors++; $display("FAIL ho_last_m0: got %b expected 101", {m0_grant, m1_grant, s1_sel});
        end
        cyc();
        m1_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({m0_grant, m1_grant} !== 2'b01 || s_addr !== 16'h0021 || s_wr !== 1'b1) begin
            errors++; $display("FAIL ho_switch: grants=%b s_addr=%h s_wr=%b expected 01/0021/1", {m0_grant, m1_grant}, s_addr, s_wr);
        end
        exp_v = exp_q.pop_front();
        checks++;
        $display("rd ho_cross m_din=%h", m_din);
        if (m_din !== exp_v) begin
            errors++; $display("FAIL ho_cross_read: got %h expected %h", m_din, exp_v);
        end
        cyc();
        m1_wr = 1'b0;
        @(negedge clk);
        checks++;
        if ({m0_grant, m1_grant} !== 2'b00) begin
            errors++; $display("FAIL ho_idle: grants=%b expected 00", {m0_grant, m1_grant});
        end
    endtask

    task automatic test_preempt();
        logic exp0;
        m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 16'h0002;
        m1_req = 1'b1; m1_wr = 1'b0; m1_addr = 16'h0022;
        for (int i = 0; i < 20; i++) begin
            cyc();
            @(negedge clk);
            exp0 = ((i / 8) % 2) == 0;
            checks++;
            if (m0_grant !== exp0 || m1_grant !== !exp0) begin
                errors++; $display("FAIL pre_hold8 cycle %0d: grants=%b%b expected %b%b", i, m0_grant, m1_grant, exp0, !exp0);
            end
            checks++;
            if (nh_m0_grant !== 1'b1 || nh_m1_grant !== 1'b0 || nh_s_addr !== 16'h0002) begin
                errors++; $display("FAIL pre_hold0 cycle %0d: grants=%b%b s_addr=%h expected 10/0002", i, nh_m0_grant, nh_m1_grant, nh_s_addr);
            end
        end
        cyc();
        m0_req = 1'b0; m1_req = 1'b0;
        cyc();
        @(negedge clk);
        checks++;
        if ({m0_grant, m1_grant, nh_m0_grant, nh_m1_grant} !== 4'b0) begin
            errors++; $display("FAIL pre_idle: got %b expected 0000", {m0_grant, m1_grant, nh_m0_grant, nh_m1_grant});
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] wa [4];
        logic [63:0] wd [4];
        logic [15:0] ra [8];
        logic [63:0] rd [8];
        wa = '{16'h0004, 16'h0024, 16'h003F, 16'h0000};
        wd = '{64'hA4A4_0004, 64'hB4B4_0024, 64'hBFBF_003F, 64'hA0A0_0000};
        ra = '{16'h0004, 16'h0024, 16'h0010, 16'h001F, 16'h003F, 16'h0000, 16'h0020, 16'h0021};
        rd = '{64'hA4A4_0004, 64'hB4B4_0024, 64'h2222, 64'h1F1F, 64'hBFBF_003F, 64'hA0A0_0000, 64'h3333, 64'h2121};
        m1_req = 1'b1; m1_wr = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            m1_addr = wa[k]; m1_dout = wd[k];
            @(negedge clk);
            checks++;
            if (m1_grant !== 1'b1 || s_wr !== 1'b1 || s_addr !== wa[k] || s_din !== wd[k]) begin
                errors++; $display("FAIL b2b_wr %0d: grant=%b s_wr=%b s_addr=%h s_din=%h expected 1/1/%h/%h", k, m1_grant, s_wr, s_addr, s_din, wa[k], wd[k]);
            end
        end
        for (int k = 0; k < 8; k++) begin
            cyc();
            m1_wr = 1'b0; m1_addr = ra[k]; m1_req = (k < 7);
            exp_q.push_back(rd[k]);
            @(negedge clk);
            if (k > 0) begin
                exp_v = exp_q.pop_front();
                checks++;
                $display("rd b2b addr=%h m_din=%h", ra[k-1], m_din);
                if (m_din !== exp_v) begin
                    errors++; $display("FAIL b2b_rd addr %h: got %h expected %h", ra[k-1], m_din, exp_v);
                end
            end
        end
        cyc();
        @(negedge clk);
        exp_v = exp_q.pop_front();
        checks++;
        $display("rd b2b addr=%h m_din=%h", ra[7], m_din);
        if (m_din !== exp_v) begin
            errors++; $display("FAIL b2b_rd addr %h: got %h expected %h", ra[7], m_din, exp_v);
        end
        checks++;
        if (m1_grant !== 1'b0) begin
            errors++; $display("FAIL b2b_release: m1_grant=%b expected 0", m1_grant);
        end
    endtask

    task automatic test_reset_mid();
        m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 16'h0020;
        cyc();
        reset_n = 1'b0;
        exp_q.push_back(64'h0);
        @(negedge clk);
        checks++;
        if ({m0_grant, s1_sel} !== 2'b11) begin
            errors++; $display("FAIL rstmid_sync: got %b expected 11", {m0_grant, s1_sel});
        end
        cyc();
        @(negedge clk);
        exp_v = exp_q.pop_front();
        checks++;
        $display("rd rstmid m_din=%h", m_din);
        if (m_din !== exp_v) begin
            errors++; $display("FAIL rstmid_discard: got %h expected %h", m_din, exp_v);
        end
        checks++;
        if ({m0_grant, m1_grant, s1_sel} !== 3'b000) begin
            errors++; $display("FAIL rstmid_idle: got %b expected 000", {m0_grant, m1_grant, s1_sel});
        end
        cyc();
        reset_n = 1'b1; m0_req = 1'b0;
        cyc();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        m0_req = 1'b0; m1_req = 1'b0; m0_wr = 1'b0; m1_wr = 1'b0;
        m0_addr = '0; m1_addr = '0; m0_dout = '0; m1_dout = '0;
        test_reset();
        test_single_rw();
        test_decode();
        test_handover();
        test_preempt();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
